// File: rtl/onehot_event_encoder_if.sv
// Valid/ready stream that carries the encoded event code from the encoder to its consumer.
interface onehot_event_encoder_if #(
  parameter int CODE_WIDTH = 3
);
  logic [CODE_WIDTH-1:0] code_out;
  logic                  code_valid;
  logic                  code_ready;

  modport master (output code_out, output code_valid, input code_ready);
  modport slave  (input code_out, input code_valid, output code_ready);
endinterface

// File: rtl/onehot_event_encoder.sv
// Synchronizes request lines, latches rising edges as pending events and streams them as codes.
// Define ENCODER_ROUND_ROBIN_EN for round-robin arbitration; default is highest-index priority.
module onehot_event_encoder #(
  parameter int IN_WIDTH    = 7,
  parameter int CODE_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IN_WIDTH-1:0]      req_in,
  onehot_event_encoder_if.master   stream,
  output logic [IN_WIDTH-1:0]      pending_out,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int IDX_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] sync_reg;
  logic [IN_WIDTH-1:0]   sync_out;
  logic [IN_WIDTH-1:0]   prev_reg;
  logic [IN_WIDTH-1:0]   rise_det;
  logic [IN_WIDTH-1:0]   pending_reg, pending_next;
  logic [IN_WIDTH-1:0]   clr_mask;
  logic [CODE_WIDTH-1:0] code_reg, code_next;
  logic                  valid_reg, valid_next;
  logic                  overflow_reg, overflow_next;
  logic                  load_en;
  logic                  take;
  logic                  ovf_hit;
  logic                  sel_found;
  logic [CODE_WIDTH-1:0] sel_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      sync_reg[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= sync_reg[s-1];
      end
      prev_reg <= sync_out;
    end
  end

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign load_en  = ~valid_reg | stream.code_ready;
  assign take     = load_en & sel_found;

  genvar gi;
  generate
    for (gi = 0; gi < IN_WIDTH; gi++) begin : g_line
      assign rise_det[gi] = sync_out[gi] & ~prev_reg[gi];
      assign clr_mask[gi] = take & (sel_idx == CODE_WIDTH'(gi));
    end
  endgenerate

  // A line being loaded this cycle has room for one more event, so only untouched bits overflow.
  assign ovf_hit = |(rise_det & pending_reg & ~clr_mask);

`ifdef ENCODER_ROUND_ROBIN_EN
  logic [CODE_WIDTH-1:0] ptr_reg;

  always_comb begin
    int cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = 1; i <= IN_WIDTH; i++) begin
      cand = int'(ptr_reg) + i;
      if (cand >= IN_WIDTH) cand = cand - IN_WIDTH;
      if (!sel_found && pending_reg[IDX_W'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = CODE_WIDTH'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= CODE_WIDTH'(IN_WIDTH - 1);
    end else if (take) begin
      ptr_reg <= sel_idx;
    end
  end
`else
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (pending_reg[i]) begin
        sel_found = 1'b1;
        sel_idx   = CODE_WIDTH'(i);
      end
    end
  end
`endif

  always_comb begin
    pending_next  = (pending_reg & ~clr_mask) | rise_det;
    overflow_next = overflow_reg;
    code_next     = code_reg;
    valid_next    = valid_reg;
    if (ovf_hit) begin
      overflow_next = 1'b1;
    end else if (overflow_clr) begin
      overflow_next = 1'b0;
    end
    if (load_en) begin
      if (sel_found) begin
        code_next  = sel_idx + CODE_WIDTH'(1);
        valid_next = 1'b1;
      end else begin
        code_next  = '0;
        valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg  <= '0;
      overflow_reg <= 1'b0;
      code_reg     <= '0;
      valid_reg    <= 1'b0;
    end else begin
      pending_reg  <= pending_next;
      overflow_reg <= overflow_next;
      code_reg     <= code_next;
      valid_reg    <= valid_next;
    end
  end

  assign stream.code_out   = code_reg;
  assign stream.code_valid = valid_reg;
  assign pending_out       = pending_reg;
  assign overflow          = overflow_reg;

endmodule

// File: tb/tb_onehot_event_encoder.sv
// Randomized and directed checks of onehot_event_encoder against an event-level reference model.
module tb_onehot_event_encoder;

  localparam int IN_W   = 7;
  localparam int CODE_W = 3;
  localparam int SYNC   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IN_W-1:0] req_in = '0;
  logic [IN_W-1:0] pending_out;
  logic            overflow;
  logic            overflow_clr = 1'b0;

  onehot_event_encoder_if #(.CODE_WIDTH(CODE_W)) stream_if ();

  onehot_event_encoder #(
    .IN_WIDTH(IN_W), .CODE_WIDTH(CODE_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .stream(stream_if),
    .pending_out(pending_out), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: raw input history, pending set, output slot, sticky loss flag, last winner.
  bit [IN_W-1:0] hist [$];
  bit [IN_W-1:0] m_pend;
  bit            m_valid;
  int            m_code;
  bit            m_ovf;
  int            m_ptr;
  int            obs [$];

  task automatic check_val(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i <= SYNC; i++) hist.push_back('0);
    m_pend = '0; m_valid = 1'b0; m_code = 0; m_ovf = 1'b0; m_ptr = IN_W - 1;
  endtask

  task automatic model_step(input bit [IN_W-1:0] req, input bit ready, input bit clr);
    bit [IN_W-1:0] ev;
    int pick;
    int k;
    bit lost;
    // An input seen SYNC edges ago and low one edge before that is a new event now.
    ev = hist[SYNC-1] & ~hist[SYNC];
    hist.push_front(req);
    void'(hist.pop_back());
    if (!m_valid || ready) begin
      pick = -1;
`ifdef ENCODER_ROUND_ROBIN_EN
      for (int n = 1; n <= IN_W; n++) begin
        k = (m_ptr + n) % IN_W;
        if (pick < 0 && m_pend[k]) pick = k;
      end
`else
      for (int j = IN_W - 1; j >= 0; j--) if (pick < 0 && m_pend[j]) pick = j;
`endif
      if (pick >= 0) begin
        m_code = pick + 1; m_valid = 1'b1; m_pend[pick] = 1'b0; m_ptr = pick;
      end else begin
        m_code = 0; m_valid = 1'b0;
      end
    end
    lost = 1'b0;
    for (int j = 0; j < IN_W; j++) begin
      if (ev[j]) begin
        if (m_pend[j]) lost = 1'b1;
        m_pend[j] = 1'b1;
      end
    end
    if (lost) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic check_outputs();
    check_val("code_valid", int'(stream_if.code_valid), int'(m_valid));
    check_val("code_out", int'(stream_if.code_out), m_code);
    check_val("pending_out", int'(pending_out), int'(m_pend));
    check_val("overflow", int'(overflow), int'(m_ovf));
  endtask

  // Called at a falling edge: drive, clock, update model, check at next falling edge.
  task automatic cycle(input bit [IN_W-1:0] req, input bit ready, input bit clr);
    req_in = req;
    stream_if.code_ready = ready;
    overflow_clr = clr;
    if (stream_if.code_valid && ready) obs.push_back(int'(stream_if.code_out));
    @(posedge clk);
    model_step(req, ready, clr);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic hold_reset(input bit [IN_W-1:0] req);
    rst_n = 1'b0;
    req_in = req;
    stream_if.code_ready = 1'b0;
    overflow_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    bit [IN_W-1:0] rq;
    int exp_a;
    int exp_b;
    stream_if.code_ready = 1'b0;
    @(negedge clk);
    hold_reset('0);

    // Single pulse on line 0
    obs.delete();
    repeat (3) cycle(7'b0000001, 1'b1, 1'b0);
    repeat (6) cycle('0, 1'b1, 1'b0);
    check_val("t1_count", obs.size(), 1);
    if (obs.size() > 0) check_val("t1_code", obs[0], 1);

    // Simultaneous lines 2 and 5
    obs.delete();
    cycle(7'b0100100, 1'b1, 1'b0);
    repeat (8) cycle('0, 1'b1, 1'b0);
`ifdef ENCODER_ROUND_ROBIN_EN
    exp_a = 3; exp_b = 6;
`else
    exp_a = 6; exp_b = 3;
`endif
    check_val("t2_count", obs.size(), 2);
    if (obs.size() > 1) begin
      check_val("t2_first", obs[0], exp_a);
      check_val("t2_second", obs[1], exp_b);
    end

    // Back-pressure hold with code 4 while line 6 arrives
    obs.delete();
    cycle(7'b0001000, 1'b0, 1'b0);
    repeat (4) cycle('0, 1'b0, 1'b0);
    cycle(7'b1000000, 1'b0, 1'b0);
    repeat (4) cycle('0, 1'b0, 1'b0);
    check_val("t3_hold_code", int'(stream_if.code_out), 4);
    check_val("t3_pend6", int'(pending_out[6]), 1);
    repeat (6) cycle('0, 1'b1, 1'b0);
    check_val("t3_count", obs.size(), 2);
    if (obs.size() > 1) begin
      check_val("t3_first", obs[0], 4);
      check_val("t3_second", obs[1], 7);
    end

    // Second event on a still-pending line is lost and flagged
    cycle(7'b0000001, 1'b0, 1'b0);
    repeat (4) cycle('0, 1'b0, 1'b0);
    cycle(7'b0000010, 1'b0, 1'b0);
    repeat (2) cycle('0, 1'b0, 1'b0);
    cycle(7'b0000010, 1'b0, 1'b0);
    repeat (4) cycle('0, 1'b0, 1'b0);
    check_val("t4_overflow", int'(overflow), 1);
    check_val("t4_pend1", int'(pending_out[1]), 1);
    cycle('0, 1'b0, 1'b1);
    check_val("t4_cleared", int'(overflow), 0);
    repeat (6) cycle('0, 1'b1, 1'b0);

    // All lines high across reset release
    hold_reset('1);
    obs.delete();
    repeat (30) cycle('1, 1'b1, 1'b0);
    check_val("t5_count", obs.size(), 7);
    for (int i = 0; i < obs.size() && i < 7; i++) begin
`ifdef ENCODER_ROUND_ROBIN_EN
      check_val("t5_order", obs[i], i + 1);
`else
      check_val("t5_order", obs[i], 7 - i);
`endif
    end
    repeat (4) cycle('0, 1'b1, 1'b0);

    // Randomized traffic
    rq = '0;
    for (int n = 0; n < 1500; n++) begin
      bit [IN_W-1:0] flip;
      for (int b = 0; b < IN_W; b++) flip[b] = ($urandom_range(0, 9) == 0);
      rq = rq ^ flip;
      cycle(rq, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset with an event in flight and more pending
    repeat (4) cycle('0, 1'b0, 1'b0);
    cycle(7'b0110011, 1'b0, 1'b0);
    repeat (4) cycle('0, 1'b0, 1'b0);
    check_val("t6_valid_before", int'(stream_if.code_valid), 1);
    check_val("t6_pend_before", int'(pending_out != '0), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_async_valid", int'(stream_if.code_valid), 0);
    check_val("t6_async_code", int'(stream_if.code_out), 0);
    check_val("t6_async_pend", int'(pending_out), 0);
    check_val("t6_async_ovf", int'(overflow), 0);
    @(negedge clk);
    hold_reset('0);
    obs.delete();
    repeat (10) cycle('0, 1'b1, 1'b0);
    check_val("t6_no_codes", obs.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/onehot_event_encoder.md
Name: onehot_event_encoder

Overview:
Inverse of the team's 3-to-7 one-hot decoder. Seven asynchronous request lines (buttons, strobes) are synchronized and rising-edge detected. Each event is latched as pending and emitted as a 3-bit code over a valid/ready stream. Request line k maps to code k+1; code 0 is never emitted. The block sits between board inputs and downstream consumers such as the display or command logic.

Parameters:
IN_WIDTH, 7, number of request lines; code k+1 for line k; must be <= 2**CODE_WIDTH-1
CODE_WIDTH, 3, width of emitted code
SYNC_STAGES, 2, synchronizer flops per request line (>= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_in  input  IN_WIDTH  asynchronous request lines, active high
code_out  output  CODE_WIDTH  encoded event, valid when code_valid=1
code_valid  output  1  code_out holds an unconsumed event
code_ready  input  1  consumer accepts code_out this cycle
pending_out  output  IN_WIDTH  events latched but not yet emitted
overflow  output  1  sticky: an event was lost
overflow_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low: asserting rst_n=0 clears all state immediately, regardless of clk. While rst_n=0: sync chain, edge history, pending_out, code_out, code_valid and overflow are all 0. The RR pointer (when enabled) is IN_WIDTH-1.
- Synchronizer: req_in passes through SYNC_STAGES flops. An edge-history flop holds the previous synchronized value.
- Rising-edge detect: edge[k] = sync[k] & ~prev[k]. A line already high at reset release produces exactly one event.
- Latency with SYNC_STAGES=2, req_in rising before edge E:
  - pending bit set after edge E+2.
  - code_valid=1 with the code after edge E+3, if the output register is free.
- Output register load: loaded from pending when code_valid=0, or when code_valid & code_ready (back-to-back, no bubble). The selected pending bit is cleared in the same cycle it is loaded.
- Fixed priority (default): highest pending index wins (line 6 -> code 7).
- Handshake hold: while code_valid=1 and code_ready=0, code_out and code_valid hold stable. code_valid drops only after a transfer with pending empty.
- New edge on bit k while pending[k]=1 and k is not being loaded this cycle:
  - event is dropped; overflow<=1.
  - pending[k] stays 1.
- Same-cycle set/clear: edge on bit k in the same cycle k is loaded into the output. pending[k] stays 1 (second event retained); no overflow.
- overflow_clr together with a new overflow condition: set wins, overflow=1.
- Falling edges and held-high levels generate no events.
- Reset mid-operation discards pending events and any in-flight code. code_valid drops asynchronously.

Optional Feature:
- Macro ENCODER_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A pointer holds the last emitted index. The search starts at pointer+1, wrapping modulo IN_WIDTH, and the pointer updates on each load. With all lines pending, codes cycle 1,2,...,7,1...
- Undefined: fixed highest-index priority, no pointer logic.

Test Plan:
1. After reset, pulse req_in[0] high for 3 cycles -> pending_out=0000001 at E+2. Then code_valid=1 with code_out=1 at E+3. With code_ready=1, one transfer occurs, then code_valid=0.
2. Raise req_in[2] and req_in[5] in the same cycle, code_ready=1 -> emit code 6, then code 3 on consecutive cycles. With ENCODER_ROUND_ROBIN_EN defined and pointer reset to 6, emit code 3 then 6.
3. Hold code_ready=0 with code 4 valid and pulse req_in[6] -> code_out stays 4 and pending_out[6]=1. Raise code_ready -> code 4 transfers, then code 7.
4. With code_ready=0, pulse req_in[1] twice, both edges registering while pending[1]=1 -> overflow=1, pending_out[1]=1. Pulse overflow_clr -> overflow=0.
5. Hold req_in=1111111 across reset release -> exactly seven codes emitted (order per arbitration mode), with no further events while held.
6. Assert rst_n=0 mid-stream with code_valid=1 and pending nonzero -> all outputs 0 immediately without a clk edge. After release with req_in=0, no codes are emitted.
